// File: rtl/hazard_pkg.sv
// Shared types and defaults for the pipeline hazard sequencer.
package hazard_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_HALTED   = 2'd2
    } hazard_state_e;

    localparam int unsigned WAIT_MAX_DEF = 32'd255;
    localparam int unsigned WAIT_W_DEF   = 32'd8;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath (master) and the sequencer (slave).
// Perf counter signals exist only when HAZARD_PERF_EN is defined.
interface pipe_hazard_ctrl_if;
    logic load_use_stall;
    logic ex_redirect;
    logic mem_req;
    logic mem_ready;
    logic wb_halt;
    logic pc_we;
    logic ifid_we;
    logic idex_we;
    logic exmem_we;
    logic memwb_we;
    logic ifid_bubble;
    logic idex_bubble;
    logic flush_id;
    logic flush_ex;
    logic halted;
    logic mem_err;
`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    modport slave (
        input  load_use_stall, ex_redirect, mem_req, mem_ready, wb_halt,
        output pc_we, ifid_we, idex_we, exmem_we, memwb_we,
        output ifid_bubble, idex_bubble, flush_id, flush_ex, halted, mem_err
`ifdef HAZARD_PERF_EN
        , output perf_stall_cnt, perf_flush_cnt
`endif
    );

    modport master (
        output load_use_stall, ex_redirect, mem_req, mem_ready, wb_halt,
        input  pc_we, ifid_we, idex_we, exmem_we, memwb_we,
        input  ifid_bubble, idex_bubble, flush_id, flush_ex, halted, mem_err
`ifdef HAZARD_PERF_EN
        , input perf_stall_cnt, perf_flush_cnt
`endif
    );
endinterface

// File: rtl/hazard_wait_timer.sv
// Counts consecutive data-memory wait cycles; expired flags the timeout limit.
module hazard_wait_timer
    import hazard_pkg::*;
#(
    parameter int unsigned WAIT_MAX = WAIT_MAX_DEF,
    parameter int unsigned WAIT_W   = WAIT_W_DEF
) (
    input  logic CLK,
    input  logic RST,
    input  logic inc_i,
    input  logic clr_i,
    output logic expired_o
);

    logic [WAIT_W-1:0] cnt_q;
    logic [WAIT_W-1:0] cnt_d;

    // Next count: clear dominates increment
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = {WAIT_W{1'b0}};
        end else if (inc_i) begin
            cnt_d = cnt_q + WAIT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q <= {WAIT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == WAIT_W'(WAIT_MAX));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: stall/redirect/memory-wait/halt arbitration into stage enables.
// Optional perf counters enabled by defining HAZARD_PERF_EN.
module pipe_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned WAIT_MAX = WAIT_MAX_DEF,
    parameter int unsigned WAIT_W   = WAIT_W_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    pipe_hazard_ctrl_if.slave bus
);

    hazard_state_e state_q, state_d;
    logic flush_id_q, flush_id_d;
    logic flush_ex_q, flush_ex_d;
    logic halted_q, halted_d;
    logic mem_err_q, mem_err_d;
    logic [4:0] we_s;
    logic [1:0] bub_s;
    logic mem_block_s;
    logic tmr_inc_s;
    logic tmr_clr_s;
    logic tmr_expired_s;

    // While waiting the request is frozen upstream, so only ready matters
    assign mem_block_s = (state_q == ST_RUN) ? (bus.mem_req & ~bus.mem_ready) : ~bus.mem_ready;

    hazard_wait_timer #(
        .WAIT_MAX (WAIT_MAX),
        .WAIT_W   (WAIT_W)
    ) u_wait_timer (
        .CLK       (CLK),
        .RST       (RST),
        .inc_i     (tmr_inc_s),
        .clr_i     (tmr_clr_s),
        .expired_o (tmr_expired_s)
    );

    // Priority arbitration: halt > memory wait > redirect > load-use
    always_comb begin
        we_s       = 5'b00000;
        bub_s      = 2'b00;
        state_d    = state_q;
        flush_id_d = flush_id_q;
        flush_ex_d = flush_ex_q;
        halted_d   = halted_q;
        mem_err_d  = mem_err_q;
        tmr_inc_s  = 1'b0;
        tmr_clr_s  = 1'b0;
        if (RST) begin
            state_d = ST_RUN;
        end else begin
            case (state_q)
                ST_RUN, ST_MEM_WAIT: begin
                    if (bus.wb_halt) begin
                        state_d    = ST_HALTED;
                        halted_d   = 1'b1;
                        flush_id_d = 1'b0;
                        flush_ex_d = 1'b0;
                        tmr_clr_s  = 1'b1;
                    end else if (mem_block_s) begin
                        if (state_q == ST_RUN) begin
                            state_d   = ST_MEM_WAIT;
                            tmr_inc_s = 1'b1;
                        end else if (tmr_expired_s) begin
                            state_d   = ST_HALTED;
                            halted_d  = 1'b1;
                            mem_err_d = 1'b1;
                            tmr_clr_s = 1'b1;
                        end else begin
                            tmr_inc_s = 1'b1;
                        end
                    end else begin
                        state_d   = ST_RUN;
                        tmr_clr_s = 1'b1;
                        if (bus.ex_redirect) begin
                            we_s       = 5'b11111;
                            bub_s      = 2'b11;
                            flush_id_d = 1'b1;
                            flush_ex_d = 1'b1;
                        end else if (bus.load_use_stall) begin
                            we_s       = 5'b00111;
                            bub_s      = 2'b01;
                            flush_id_d = 1'b0;
                            flush_ex_d = 1'b1;
                        end else begin
                            we_s       = 5'b11111;
                            flush_id_d = 1'b0;
                            flush_ex_d = 1'b0;
                        end
                    end
                end
                ST_HALTED: begin
                    state_d = ST_HALTED;
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    // State and registered status flags
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_RUN;
            flush_id_q <= 1'b0;
            flush_ex_q <= 1'b0;
            halted_q   <= 1'b0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            flush_id_q <= flush_id_d;
            flush_ex_q <= flush_ex_d;
            halted_q   <= halted_d;
            mem_err_q  <= mem_err_d;
        end
    end

    assign bus.pc_we       = we_s[4];
    assign bus.ifid_we     = we_s[3];
    assign bus.idex_we     = we_s[2];
    assign bus.exmem_we    = we_s[1];
    assign bus.memwb_we    = we_s[0];
    assign bus.ifid_bubble = bub_s[1];
    assign bus.idex_bubble = bub_s[0];
    assign bus.flush_id    = flush_id_q;
    assign bus.flush_ex    = flush_ex_q;
    assign bus.halted      = halted_q;
    assign bus.mem_err     = mem_err_q;

`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall_q;
    logic [31:0] perf_flush_q;
    logic        redirect_acc_s;

    // Only an accepted redirect drives pc_we together with an IF/ID bubble
    assign redirect_acc_s = we_s[4] & bub_s[1];

    // Performance counters
    always_ff @(posedge CLK) begin
        if (RST) begin
            perf_stall_q <= 32'd0;
            perf_flush_q <= 32'd0;
        end else begin
            if ((state_q != ST_HALTED) && !we_s[4]) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
            if (redirect_acc_s) begin
                perf_flush_q <= perf_flush_q + 32'd1;
            end
        end
    end

    assign bus.perf_stall_cnt = perf_stall_q;
    assign bus.perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized self-checking bench for pipe_hazard_ctrl against a rule-level reference model.
module tb_pipe_hazard_ctrl;

    localparam int unsigned T_WAIT_MAX = 4;

    logic CLK;
    logic RST;
    int   n_run;
    int   n_fail;

    pipe_hazard_ctrl_if bus ();

    pipe_hazard_ctrl #(
        .WAIT_MAX (T_WAIT_MAX),
        .WAIT_W   (8)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model state (values visible on registered outputs this cycle)
    bit          m_halted, m_err, m_fid, m_fex, m_waiting;
    int          m_wait_n;
    bit [31:0]   m_pstall, m_pflush;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // One cycle: drive inputs after negedge, check, then advance the model
    task automatic step(input bit rst, input bit lus, input bit red,
                        input bit req, input bit rdy, input bit halt);
        bit [4:0] e_we;
        bit [1:0] e_bub;
        bit       blocked;
        @(negedge CLK);
        RST                = rst;
        bus.load_use_stall = lus;
        bus.ex_redirect    = red;
        bus.mem_req        = req;
        bus.mem_ready      = rdy;
        bus.wb_halt        = halt;
        #1;
        e_we  = 5'b00000;
        e_bub = 2'b00;
        if (!rst && !m_halted && !halt) begin
            blocked = m_waiting ? !rdy : (req && !rdy);
            if (!blocked) begin
                if (red) begin
                    e_we = 5'b11111; e_bub = 2'b11;
                end else if (lus) begin
                    e_we = 5'b00111; e_bub = 2'b01;
                end else begin
                    e_we = 5'b11111;
                end
            end
        end
        check("we", 32'({bus.pc_we, bus.ifid_we, bus.idex_we, bus.exmem_we, bus.memwb_we}), 32'(e_we));
        check("bubble", 32'({bus.ifid_bubble, bus.idex_bubble}), 32'(e_bub));
        check("flush", 32'({bus.flush_id, bus.flush_ex}), 32'({m_fid, m_fex}));
        check("halted", 32'(bus.halted), 32'(m_halted));
        check("mem_err", 32'(bus.mem_err), 32'(m_err));
`ifdef HAZARD_PERF_EN
        check("perf_stall", bus.perf_stall_cnt, m_pstall);
        check("perf_flush", bus.perf_flush_cnt, m_pflush);
`endif
        if (rst) begin
            m_halted = 0; m_err = 0; m_fid = 0; m_fex = 0;
            m_waiting = 0; m_wait_n = 0; m_pstall = 0; m_pflush = 0;
        end else if (!m_halted) begin
            if (e_we[4] == 1'b0) m_pstall = m_pstall + 32'd1;
            blocked = m_waiting ? !rdy : (req && !rdy);
            if (halt) begin
                m_halted = 1; m_fid = 0; m_fex = 0; m_waiting = 0;
            end else if (blocked) begin
                if (!m_waiting) begin
                    m_waiting = 1; m_wait_n = 1;
                end else if (m_wait_n == int'(T_WAIT_MAX)) begin
                    m_halted = 1; m_err = 1; m_waiting = 0;
                end else begin
                    m_wait_n++;
                end
            end else begin
                m_waiting = 0; m_wait_n = 0;
                if (red) begin
                    m_fid = 1; m_fex = 1; m_pflush = m_pflush + 32'd1;
                end else if (lus) begin
                    m_fid = 0; m_fex = 1;
                end else begin
                    m_fid = 0; m_fex = 0;
                end
            end
        end
    endtask

    initial begin
        n_run = 0;
        n_fail = 0;
        m_halted = 0; m_err = 0; m_fid = 0; m_fex = 0;
        m_waiting = 0; m_wait_n = 0; m_pstall = 0; m_pflush = 0;
        RST = 1'b1;
        bus.load_use_stall = 1'b0;
        bus.ex_redirect    = 1'b0;
        bus.mem_req        = 1'b0;
        bus.mem_ready      = 1'b0;
        bus.wb_halt        = 1'b0;

        // Reset, idle, load-use pulse, redirect with concurrent load-use
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
`ifdef HAZARD_PERF_EN
        check("perf_stall_seq", bus.perf_stall_cnt, 32'd1);
        check("perf_flush_seq", bus.perf_flush_cnt, 32'd1);
`endif
        // Memory wait resolved after three stalled cycles
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 1, 0);
        step(0, 0, 0, 0, 0, 0);
        // Wait timeout, then halted until reset
        for (int i = 0; i < 7; i++) step(0, 0, 0, 1, 0, 0);
        step(0, 1, 1, 0, 1, 0);
        check("timeout_err", 32'(bus.mem_err), 32'd1);
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        // Halt beats a simultaneous redirect
        step(0, 0, 1, 0, 0, 1);
        step(0, 0, 1, 0, 0, 0);
        check("halt_vs_redirect", 32'(bus.halted), 32'd1);
        step(1, 0, 0, 0, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(99) < 3),
                 ($urandom_range(99) < 30),
                 ($urandom_range(99) < 20),
                 ($urandom_range(99) < 40),
                 ($urandom_range(99) < 50),
                 ($urandom_range(999) < 15));
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central sequencer for the 5-stage RV32I pipeline.
- Combines the load-use stall request, the EX-stage redirect (taken branch or jump), the data-memory wait handshake and halt retirement.
- Produces per-stage register write-enables, bubble-inserts and registered flush flags. The flush flags feed back into load-use hazard detection.
- Owns a wait-timeout counter and a HALTED state.

Parameters:
- WAIT_MAX, 255: max consecutive MEM_WAIT cycles before a memory error.
- WAIT_W, 8: width of the wait counter; must satisfy 2^WAIT_W > WAIT_MAX.

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  synchronous reset, active-high
- load_use_stall  in  1  load-use hazard between ID and EX
- ex_redirect  in  1  EX resolves taken branch/jump; PC mux selects target
- mem_req  in  1  MEM stage holds a load/store
- mem_ready  in  1  data memory completes the access this cycle
- wb_halt  in  1  WB retires a halt instruction
- pc_we, ifid_we, idex_we, exmem_we, memwb_we  out  1 each  stage register enables
- ifid_bubble, idex_bubble  out  1 each  write NOP into IF/ID, ID/EX
- flush_id, flush_ex  out  1 each  registered: ID / EX currently hold squashed bubble
- halted  out  1  core stopped
- mem_err  out  1  sticky: memory wait timeout

Behaviour:
- Reset: RST=1 forces all *_we=0 and bubbles=0 combinationally. Next state is RUN, wait_cnt=0, flush_id=flush_ex=0, halted=0, mem_err=0.
- States: RUN, MEM_WAIT, HALTED (2-bit encoding in package). Enables/bubbles are combinational from state and inputs; flush_*, halted, mem_err are registered.
- Per-cycle priority: wb_halt > memory wait > ex_redirect > load_use_stall.
- RUN, wb_halt=1:
  - All *_we=0. The WB write of the halting instruction still completes; WB is ungated.
  - Next state HALTED, halted=1 from the next cycle.
- RUN, mem_req=1 & mem_ready=0:
  - All *_we=0, no bubbles.
  - Next state MEM_WAIT, wait_cnt=1.
- RUN, ex_redirect=1 (memory not blocking):
  - pc_we=1 (loads target), all stage we=1, ifid_bubble=1, idex_bubble=1.
  - Next cycle: flush_id=1, flush_ex=1.
  - load_use_stall is ignored this cycle; the ID instruction is wrong-path.
- RUN, load_use_stall=1 only:
  - pc_we=0, ifid_we=0, idex_we=1 with idex_bubble=1, exmem_we=memwb_we=1.
  - Exactly one bubble per cycle of assertion.
  - Next cycle: flush_ex=1, flush_id=0.
- RUN, none of the above: all we=1, no bubbles; flush_id/flush_ex clear next cycle.
- MEM_WAIT:
  - All *_we=0; flush_* hold their values.
  - mem_ready=1: this cycle is evaluated exactly as RUN with memory unblocked (redirect/load-use/halt apply). Next state per RUN rules; wait_cnt=0.
  - mem_ready=0 & wait_cnt==WAIT_MAX: next state HALTED, mem_err=1, halted=1.
  - Otherwise wait_cnt+1, stay.
  - Inputs frozen upstream stay valid because all enables are low.
- HALTED: all *_we=0, bubbles=0; held until RST. wb_halt and other inputs are ignored.
- flush_id/flush_ex are asserted only for the single cycle after the causing event.
- The stall detector qualifies with these flags, so a squashed bubble never triggers a stall.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- Defined:
  - Output perf_stall_cnt[31:0] counts cycles with pc_we=0 while not HALTED and not in reset.
  - Output perf_flush_cnt[31:0] counts accepted redirects.
  - Both reset to 0, wrap at 2^32, increment in the same cycle as the event and are visible next cycle.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package hazard_pkg holds the state typedef/encodings (ST_RUN=0, ST_MEM_WAIT=1, ST_HALTED=2) and the default WAIT_MAX.
- One sub-module, hazard_wait_timer, contains wait_cnt with inc/clear/expired. All else lives in pipe_hazard_ctrl.

Test Plan:
- Reset then idle, no inputs -> all we=1, bubbles=0, flush_*=0, halted=0 from the first cycle after RST drops.
- load_use_stall pulsed for 1 cycle -> that cycle pc_we=0, ifid_we=0, idex_bubble=1; next cycle flush_ex=1, flush_id=0, then all we=1.
- ex_redirect and load_use_stall both high in the same cycle -> pc_we=1, ifid_bubble=idex_bubble=1; next cycle flush_id=flush_ex=1; no stall cycle follows.
- mem_req=1, mem_ready low for 3 cycles then high -> 3 cycles all we=0, 4th cycle all we=1, state RUN.
- WAIT_MAX=4, mem_ready never high -> after 4 MEM_WAIT cycles mem_err=1, halted=1; all we stay 0 until RST.
- wb_halt during ex_redirect -> halt wins: all we=0, flush_* not set, halted=1 next cycle.
- With HAZARD_PERF_EN defined, run the load-use then redirect sequence -> perf_stall_cnt=1, perf_flush_cnt=1.
